// File: rtl/prog_counter.sv
// Fetch-stage program counter: start/run/halt sequencing, three PC save
// registers used as jump targets, and a saturating RUN cycle counter.
module prog_counter #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic             JumpEqual,
    input  logic             JumpNotEqual,
    input  logic             OffsetEn,
    input  logic [1:0]       PCRegSelect,
    input  logic [7:0]       SaveOffset,
    input  logic             Zero,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Done,
    output logic             Running,
    output logic [CNT_W-1:0] CycleCount
);

    localparam int AW = (PC_W > 8) ? PC_W : 8;
    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  reg1_q, reg1_d;
    logic [PC_W-1:0]  reg2_q, reg2_d;
    logic [PC_W-1:0]  reg3_q, reg3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             run_q, run_d;

    logic             jump;
    logic             taken;
    logic             sel_any;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  target;
    logic [AW-1:0]    save_sum;
    logic [PC_W-1:0]  save_val;
    logic [CNT_W-1:0] cnt_inc;

    // je and jne together act as an unconditional jump
    assign jump     = JumpEqual | JumpNotEqual;
    assign taken    = (JumpEqual & JumpNotEqual)
                    | (JumpEqual & Zero)
                    | (JumpNotEqual & ~Zero);
    assign sel_any  = |PCRegSelect;
    assign pc_inc   = pc_q + PC_W'(1);
    assign save_sum = AW'(pc_q) + AW'(1)
                    + (OffsetEn ? AW'(SaveOffset) : AW'(0));
    assign save_val = save_sum[PC_W-1:0];
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        case (PCRegSelect)
            2'd2:    target = reg2_q;
            2'd3:    target = reg3_q;
            default: target = reg1_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            reg1_q  <= '0;
            reg2_q  <= '0;
            reg3_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            reg1_q  <= reg1_d;
            reg2_q  <= reg2_d;
            reg3_q  <= reg3_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (!Start) state_d = S_RUN;
            S_RUN: begin
                if (Start)    state_d = S_IDLE;
                else if (Ack) state_d = S_HALT;
            end
            S_HALT: if (Start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        reg1_d = reg1_q;
        reg2_d = reg2_q;
        reg3_d = reg3_q;
        cnt_d  = cnt_q;
        done_d = (state_d == S_HALT);
        run_d  = (state_d == S_RUN);
        unique case (state_q)
            S_IDLE: begin
                pc_d  = START_PC;
                cnt_d = '0;
            end
            S_RUN: begin
                if (Start) begin
                    pc_d  = START_PC;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (!Ack) begin
                        if (taken && sel_any) begin
                            pc_d = target;
                        end else begin
                            pc_d = pc_inc;
                            // spc: save only when no jump is encoded
                            if (!jump && sel_any) begin
                                case (PCRegSelect)
                                    2'd1:    reg1_d = save_val;
                                    2'd2:    reg2_d = save_val;
                                    default: reg3_d = save_val;
                                endcase
                            end
                        end
                    end
                end
            end
            S_HALT: begin
                if (Start) begin
                    pc_d  = START_PC;
                    cnt_d = '0;
                end
            end
            default: begin
                pc_d  = START_PC;
                cnt_d = '0;
            end
        endcase
    end

    assign ProgCtr    = pc_q;
    assign Done       = done_q;
    assign Running    = run_q;
    assign CycleCount = cnt_q;

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
Fetch-stage program counter. It sits directly upstream of the instruction ROM and consumes the per-instruction jump/save controls decoded by the control decoder, together with the registered zero flag. It holds three PC save registers (PCreg1-3) that serve as jump targets, sequences start/run/halt, and exposes a cycle count for benchmarking.

Parameters:
PC_W, 10, width of program address (instruction ROM depth = 2**PC_W)
START_ADDR, 0, address loaded on reset and while Start is held
CNT_W, 16, width of cycle counter (saturating)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  high = hold at START_ADDR (IDLE); falling edge begins execution
Ack  input  1  halt instruction currently fetched (all-ones opcode)
JumpEqual  input  1  current instruction is je
JumpNotEqual  input  1  current instruction is jne
OffsetEn  input  1  spc saves PC+1+SaveOffset instead of PC+1
PCRegSelect  input  2  00 none, 01/10/11 select PCreg1/2/3 for jump target or save
SaveOffset  input  8  unsigned offset for spc (top level routes r8)
Zero  input  1  registered ALU zero flag
ProgCtr  output  PC_W  instruction ROM address
Done  output  1  high in HALT
Running  output  1  high in RUN
CycleCount  output  CNT_W  RUN cycles elapsed, saturating

Behaviour:
- Reset low (async): state=IDLE, ProgCtr=START_ADDR, PCreg1-3=0, Done=0, Running=0, CycleCount=0.
- States: IDLE -> RUN when Start low at a clock edge; RUN -> HALT at the edge where Ack=1; HALT -> IDLE when Start=1; RUN -> IDLE when Start=1 (restart, overrides all). HALT holds ProgCtr and all PCregs.
- IDLE: ProgCtr held at START_ADDR; CycleCount cleared to 0; PCregs keep their values (cleared only by reset).
- RUN, per edge (priority high to low):
  1. Ack=1: ProgCtr unchanged; go to HALT.
  2. Jump taken (JumpEqual&Zero, or JumpNotEqual&~Zero) with PCRegSelect!=00: ProgCtr <= selected PCreg.
  3. Jump not taken, or PCRegSelect=00 with a jump: ProgCtr <= ProgCtr+1.
  4. spc (no jump, PCRegSelect!=00): selected PCreg <= ProgCtr+1+(OffsetEn ? SaveOffset : 0), truncated to PC_W; ProgCtr <= ProgCtr+1.
  5. Otherwise: ProgCtr <= ProgCtr+1.
- JumpEqual and JumpNotEqual both high: treat as unconditional jump (taken).
- Jump whose target PCreg equals ProgCtr: legal; the PC stays (spin).
- ProgCtr+1 wraps modulo 2**PC_W; the saved address wraps the same way.
- Zero is sampled on the same edge as the jump; 1-cycle latency from control inputs to ProgCtr.
- CycleCount increments on every RUN edge, including the Ack edge; it saturates at all-ones and holds in HALT.
- Done=1 exactly while in HALT; Running=1 exactly while in RUN. Both are registered outputs.
- Reset asserted mid-RUN: immediate return to reset values, with no wait for Clk.

Test Plan:
- Reset low mid-run with ProgCtr=37 -> ProgCtr=0, Done=0, CycleCount=0 without a clock edge; release with Start=1 -> ProgCtr stays 0.
- Start 1->0, 5 plain instructions -> ProgCtr 0,1,2,3,4,5; CycleCount=5; Running=1.
- At PC=3, spc with PCRegSelect=10 and OffsetEn=0 -> PCreg2=4; at PC=9, je with PCRegSelect=10 and Zero=1 -> next ProgCtr=4; repeat with Zero=0 -> ProgCtr=10.
- At PC=6, spc with PCRegSelect=01, OffsetEn=1, SaveOffset=20 -> PCreg1=27; jne with Zero=0 -> ProgCtr=27. Then PC_W=10, PC=1020, OffsetEn=1, SaveOffset=10 -> saved value 7 (wrap).
- Ack=1 at PC=12 -> ProgCtr holds 12, Done=1, CycleCount frozen; Start=1 -> IDLE, ProgCtr=0.
- Jump with PCRegSelect=00 and Zero=1 -> ProgCtr+1. JumpEqual and JumpNotEqual both high -> taken.
